// File: rtl/fme_input_sequencer.sv
// Replays the fixed 55-cycle fme input schedule from internal pixel/original/lambda buffers.
// Optional build macro FME_SEQ_DOUBLE_BUFFER_EN: ping-pong pixel banks so pixels can be loaded while streaming.
module fme_input_sequencer #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [1:0]           wr_sel,
    input  logic [7:0]           wr_addr,
    input  logic [DATAWIDTH+7:0] wr_data,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 wr_err,
    output logic                 fme_enable,
    output logic [DATAWIDTH-1:0] in_0,
    output logic [DATAWIDTH-1:0] in_1,
    output logic [DATAWIDTH-1:0] in_2,
    output logic [DATAWIDTH-1:0] in_3,
    output logic [DATAWIDTH-1:0] in_4,
    output logic [DATAWIDTH-1:0] in_5,
    output logic [DATAWIDTH-1:0] in_6,
    output logic [DATAWIDTH-1:0] in_7,
    output logic [DATAWIDTH-1:0] in_8,
    output logic [DATAWIDTH-1:0] in_9,
    output logic [DATAWIDTH-1:0] in_10,
    output logic [DATAWIDTH-1:0] in_11,
    output logic [DATAWIDTH-1:0] in_12,
    output logic [DATAWIDTH-1:0] in_13,
    output logic [DATAWIDTH-1:0] in_14,
    output logic [DATAWIDTH-1:0] in_15,
    output logic [DATAWIDTH-1:0] original_0,
    output logic [DATAWIDTH-1:0] original_1,
    output logic [DATAWIDTH-1:0] original_2,
    output logic [DATAWIDTH-1:0] original_3,
    output logic [DATAWIDTH-1:0] original_4,
    output logic [DATAWIDTH-1:0] original_5,
    output logic [DATAWIDTH-1:0] original_6,
    output logic [DATAWIDTH-1:0] original_7,
    output logic [DATAWIDTH+7:0] lambda_r_SAD_0,
    output logic [DATAWIDTH+7:0] lambda_r_SAD_1,
    output logic [DATAWIDTH+7:0] lambda_r_SAD_2,
    output logic [DATAWIDTH+7:0] lambda_r_SAD_3,
    output logic [DATAWIDTH+7:0] lambda_r_SAD_4,
    output logic [DATAWIDTH+7:0] lambda_r_SAD_5
);
    localparam int LW = DATAWIDTH + 8;
    localparam logic [5:0] LAST_T = 6'd54;
    localparam logic [5:0] LAM_OFS [6] = '{6'd0, 6'd7, 6'd14, 6'd27, 6'd34, 6'd41};

    typedef enum logic {IDLE, RUN} state_t;
    state_t     state;
    logic [5:0] cnt;

`ifdef FME_SEQ_DOUBLE_BUFFER_EN
    localparam int   NBANK             = 2;
    localparam logic PIX_WR_WHILE_BUSY = 1'b1;
    logic play_bank;
    logic load_bank;
    assign load_bank = ~play_bank;
`else
    localparam int   NBANK             = 1;
    localparam logic PIX_WR_WHILE_BUSY = 1'b0;
    logic play_bank;
    logic load_bank;
    assign play_bank = 1'b0;
    assign load_bank = 1'b0;
`endif

    logic [DATAWIDTH-1:0] int_mem  [NBANK][256];
    logic [DATAWIDTH-1:0] orig_mem [NBANK][64];
    logic [LW-1:0]        lam_mem  [48];
    logic [DATAWIDTH-1:0] in_q     [16];
    logic [DATAWIDTH-1:0] orig_q   [8];
    logic [LW-1:0]        lam_q    [6];

    logic range_ok, busy_ok, wr_ok, lam_wr;
    always_comb begin
        range_ok = 1'b0;
        case (wr_sel)
            2'd0:    range_ok = 1'b1;
            2'd1:    range_ok = (wr_addr < 8'd64);
            2'd2:    range_ok = (wr_addr < 8'd48);
            default: range_ok = 1'b0;
        endcase
        busy_ok = !busy || (PIX_WR_WHILE_BUSY && (wr_sel != 2'd2));
        wr_ok   = wr_en && range_ok && busy_ok;
        lam_wr  = wr_ok && (wr_sel == 2'd2);
    end

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            case (wr_sel)
                2'd0:    int_mem[load_bank][wr_addr] <= wr_data[DATAWIDTH-1:0];
                2'd1:    orig_mem[load_bank][wr_addr[5:0]] <= wr_data[DATAWIDTH-1:0];
                2'd2:    lam_mem[wr_addr[5:0]] <= wr_data;
                default: ;
            endcase
        end
    end

    // start is taken when idle or in the done cycle (busy=1, done=1); any other start is dropped.
    // The edge that takes start produces the t=0 outputs.
    logic       accept, run_next, in_window, orig_window, ime;
    logic [5:0] t_next;
    logic [3:0] int_col;
    logic [2:0] orig_col, grp;
    logic [5:0] lam_idx  [6];
    logic [LW-1:0] lam_next [6];

    always_comb begin
        accept      = start && ((state == IDLE) || (cnt == LAST_T));
        run_next    = accept || ((state == RUN) && (cnt != LAST_T));
        t_next      = accept ? 6'd0 : cnt + 6'd1;
        in_window   = (t_next >= 6'd1) && (t_next <= 6'd16);
        orig_window = (t_next >= 6'd6) && (t_next <= 6'd13);
        int_col     = 4'(t_next - 6'd1);
        orig_col    = 3'(t_next - 6'd6);
        ime         = 1'b0;
        grp         = 3'd6;
        if (t_next <= 6'd16)      ime = 1'b1;
        else if (t_next <= 6'd27) grp = 3'd3;
        else if (t_next == 6'd28) grp = 3'd0;
        else if (t_next <= 6'd36) grp = 3'd4;
        else if (t_next == 6'd37) grp = 3'd1;
        else if (t_next <= 6'd45) grp = 3'd5;
        else if (t_next == 6'd46) grp = 3'd2;
        // A lambda write landing on the same edge as t=0 must be visible at t=0.
        for (int k = 0; k < 6; k++) begin
            lam_idx[k]  = ime ? (6'd21 + 6'(k)) : (LAM_OFS[k] + {3'd0, grp});
            lam_next[k] = (lam_wr && (wr_addr[5:0] == lam_idx[k])) ? wr_data : lam_mem[lam_idx[k]];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_err     <= 1'b0;
            fme_enable <= 1'b0;
            for (int r = 0; r < 16; r++) in_q[r] <= '0;
            for (int r = 0; r < 8; r++) orig_q[r] <= '0;
            for (int k = 0; k < 6; k++) lam_q[k] <= '0;
`ifdef FME_SEQ_DOUBLE_BUFFER_EN
            play_bank  <= 1'b0;
`endif
        end else begin
            wr_err <= wr_en && !wr_ok;
            if (run_next) begin
                state      <= RUN;
                cnt        <= t_next;
                busy       <= 1'b1;
                fme_enable <= 1'b1;
                done       <= (t_next == LAST_T);
                for (int k = 0; k < 6; k++) lam_q[k] <= lam_next[k];
                if (in_window)
                    for (int r = 0; r < 16; r++) in_q[r] <= int_mem[play_bank][{4'(r), int_col}];
                if (orig_window)
                    for (int r = 0; r < 8; r++) orig_q[r] <= orig_mem[play_bank][{3'(r), orig_col}];
            end else begin
                state      <= IDLE;
                busy       <= 1'b0;
                fme_enable <= 1'b0;
                done       <= 1'b0;
                for (int k = 0; k < 6; k++) lam_q[k] <= '0;
            end
`ifdef FME_SEQ_DOUBLE_BUFFER_EN
            if (accept) play_bank <= ~play_bank;
`endif
        end
    end

    assign in_0  = in_q[0];
    assign in_1  = in_q[1];
    assign in_2  = in_q[2];
    assign in_3  = in_q[3];
    assign in_4  = in_q[4];
    assign in_5  = in_q[5];
    assign in_6  = in_q[6];
    assign in_7  = in_q[7];
    assign in_8  = in_q[8];
    assign in_9  = in_q[9];
    assign in_10 = in_q[10];
    assign in_11 = in_q[11];
    assign in_12 = in_q[12];
    assign in_13 = in_q[13];
    assign in_14 = in_q[14];
    assign in_15 = in_q[15];
    assign original_0 = orig_q[0];
    assign original_1 = orig_q[1];
    assign original_2 = orig_q[2];
    assign original_3 = orig_q[3];
    assign original_4 = orig_q[4];
    assign original_5 = orig_q[5];
    assign original_6 = orig_q[6];
    assign original_7 = orig_q[7];
    assign lambda_r_SAD_0 = lam_q[0];
    assign lambda_r_SAD_1 = lam_q[1];
    assign lambda_r_SAD_2 = lam_q[2];
    assign lambda_r_SAD_3 = lam_q[3];
    assign lambda_r_SAD_4 = lam_q[4];
    assign lambda_r_SAD_5 = lam_q[5];
endmodule

// File: doc/fme_input_sequencer.md
Name: fme_input_sequencer

Overview:
- Drives the `fme` datapath input interface from internal buffers, so the block no longer depends on a testbench-style stimulus process.
- Software or upstream logic loads three buffers: a 16x16 integer-pixel window, the 8x8 original block and 48 lambda_r cost terms.
- On `start`, it replays the fixed 55-cycle schedule that `fme` expects: 16 integer columns, 8 original columns and 7 lambda groups.
- Sits between the IME result memory and `fme`.

Parameters:
- DATAWIDTH, 8, pixel width; lambda outputs are DATAWIDTH+8 bits.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- wr_en  input  1  buffer write strobe.
- wr_sel  input  2  target buffer: 0 = integer pixels (256 entries), 1 = original (64), 2 = lambda_r (48), 3 = reserved (write ignored).
- wr_addr  input  8  entry index, row-major (row*16+col for integer, row*8+col for original).
- wr_data  input  DATAWIDTH+8  write data; pixel buffers take the low DATAWIDTH bits.
- start  input  1  begin one block schedule.
- busy  output  1  schedule in progress.
- done  output  1  one-cycle pulse on the final schedule cycle.
- wr_err  output  1  one-cycle pulse when a write is dropped.
- fme_enable  output  1  drives fme.enable.
- in_0..in_15  output  DATAWIDTH each  integer column, row r on in_r.
- original_0..original_7  output  DATAWIDTH each  original column, row r on original_r.
- lambda_r_SAD_0..lambda_r_SAD_5  output  DATAWIDTH+8 each  candidate cost terms.

Behaviour:
- Reset (reset=0 at a rising edge):
  - busy, done, wr_err, fme_enable and all data outputs go to 0.
  - Buffer contents are not cleared.
  - Reset during a schedule aborts it immediately; no done pulse is issued.
- Timing and start acceptance:
  - All outputs are registered.
  - start is accepted when busy=0, or in the done cycle (back-to-back, zero gap).
  - Cycle t=0 is the first edge after acceptance. busy=1 and fme_enable=1 for t=0..54.
- Integer and original data:
  - t=1..16: in_r = int[r*16 + (t-1)].
  - t=6..13: original_r = orig[r*8 + (t-6)].
  - Outside these windows in_*/original_* hold their last value.
- Lambda groups:
  - Group g (g=0..6) selects indices {g, g+7, g+14, g+27, g+34, g+41} on SAD_0..SAD_5.
  - The IME group selects {21..26}.
- Lambda schedule:
  - t=0..16: IME group.
  - t=17..27: g=3 (t=25..27 is the pipeline gap; the value holds).
  - t=28: g=0.
  - t=29..36: g=4.
  - t=37: g=1.
  - t=38..45: g=5.
  - t=46: g=2.
  - t=47..54: g=6.
- End of schedule:
  - done=1 at t=54.
  - At t=55 with no back-to-back start: busy=0, fme_enable=0, lambdas=0, in_*/original_* hold.
- Control: a 6-bit cycle counter plus a state machine with states IDLE and RUN; lambda group selection is decoded from the counter.
- Writes:
  - A write takes effect at the edge; a read of the same entry sees it the following cycle.
  - wr_sel=2 with wr_addr>47, or wr_sel=1 with wr_addr>63, is ignored and wr_err pulses.
  - Base build: any write while busy=1 is ignored and wr_err pulses.
- start while busy (except in the done cycle) is ignored.
- Simultaneous start and wr_en in IDLE: the write completes, and t=0 uses the new data only if it targets the lambda buffer (pixel reads begin at t=1).

Optional Feature:
- Macro: FME_SEQ_DOUBLE_BUFFER_EN.
- When defined:
  - The integer and original buffers are duplicated into banks A/B.
  - Writes go to the load bank; streaming reads the play bank.
  - Banks swap on each accepted start; the bank pointer resets to A=play.
  - Pixel writes while busy are accepted, with no wr_err.
  - Lambda writes while busy still drop and pulse wr_err.
- When undefined: a single bank, and the base write-while-busy rule applies.

Test Plan:
- Reset check: hold reset=0 for 2 cycles mid-schedule (t=20) -> next edge all outputs 0, busy=0, no done; a new start replays from t=0.
- Column streaming: load int[a]=a[7:0], start -> t=1: in_5=80, in_0=0; t=16: in_15=255, in_0=15; t=17: in_15 holds 255.
- Original streaming: load orig[a]=a+1 -> t=6: original_7=57, original_0=1; t=13: original_7=64; t=14: holds 64.
- Lambda schedule: load lambda[n]=n+100 -> t=0: SAD_0=121, SAD_5=126; t=17: SAD_5=144; t=27: SAD_0=103; t=28: SAD_0=100, SAD_3=127; t=54: SAD_5=147, done=1; t=55: all lambdas 0, busy=0.
- Back-to-back: start held high through both schedules -> done at t=54, second schedule's t=0 at the next edge (SAD_0=121), fme_enable stays 1 continuously for 110 cycles.
- Write errors: wr_sel=2, wr_addr=48 -> wr_err pulse, buffer unchanged. Pixel write during busy -> wr_err=1 in the base build, accepted with wr_err=0 with FME_SEQ_DOUBLE_BUFFER_EN; after the next start, in_0 at t=1 shows the new value.
